// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel-rate raster timing generator with optional test
// pattern source.
//   - Horizontal/vertical counters walk the full raster including porches.
//   - de/hs/vs/rgb/pix_x/pix_y/frame_start are registered one ce-cycle after
//     the counter state they describe.
//   - Compile-time option VTG_PATTERN_EN: when defined, a pattern generator
//     (solid / colour bars / gradient / checker) drives hdmi_r/g/b. When
//     undefined, rgb is tied to zero and mode/solid_rgb are ignored.
//   - ce low freezes every register, so pulses stretch instead of being lost.
//   - Handshake: there is no valid/ready; hdmi_de is the qualifier for pixel
//     data, and a new output set is presented on every clock edge where ce=1.
module video_timing_gen #(
    parameter int HR     = 800,
    parameter int HFP    = 8,
    parameter int HS     = 2,
    parameter int HBP    = 8,
    parameter int VR     = 300,
    parameter int VFP    = 8,
    parameter int VS     = 4,
    parameter int VBP    = 8,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int CW     = 12
) (
    input  logic          hdmi_clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          hdmi_de,
    output logic          hdmi_hs,
    output logic          hdmi_vs,
    output logic [7:0]    hdmi_r,
    output logic [7:0]    hdmi_g,
    output logic [7:0]    hdmi_b,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          frame_start
);

    localparam logic [CW-1:0] H_LAST   = CW'(HR + HFP + HS + HBP - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VR + VFP + VS + VBP - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(HR);
    localparam logic [CW-1:0] V_ACT    = CW'(VR);
    localparam logic [CW-1:0] HS_START = CW'(HR + HFP);
    localparam logic [CW-1:0] HS_END   = CW'(HR + HFP + HS);
    localparam logic [CW-1:0] VS_START = CW'(VR + VFP);
    localparam logic [CW-1:0] VS_END   = CW'(VR + VFP + VS);

    // Counter state: position of the pixel being generated this cycle.
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          h_wrap;
    logic          v_wrap;
    logic          active;
    logic          hs_asserted;
    logic          vs_asserted;
    logic          frame_pos;

    assign h_wrap      = (h == H_LAST);
    assign v_wrap      = (v == V_LAST);
    assign active      = (h < H_ACT) && (v < V_ACT);
    assign hs_asserted = (h >= HS_START) && (h < HS_END);
    assign vs_asserted = (v >= VS_START) && (v < VS_END);
    assign frame_pos   = (h == '0) && (v == '0);

    // Raster counters; reset parks v in vertical blanking so the first
    // frame after reset always starts with a full blanking interval.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= V_ACT;
        end else if (ce) begin
            if (h_wrap) begin
                h <= '0;
                v <= v_wrap ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Registered timing outputs and coordinates (held through blanking).
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdmi_de     <= 1'b0;
            hdmi_hs     <= !HS_POL;
            hdmi_vs     <= !VS_POL;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hdmi_de     <= active;
            hdmi_hs     <= hs_asserted ? HS_POL : !HS_POL;
            hdmi_vs     <= vs_asserted ? VS_POL : !VS_POL;
            frame_start <= frame_pos;
            if (active) begin
                pix_x <= h;
                pix_y <= v;
            end
        end
    end

`ifdef VTG_PATTERN_EN
    // Bar width in pixels; bars beyond index 7 are black.
    localparam int            BW      = HR / 8;
    localparam logic [CW-1:0] BW_LAST = CW'(BW - 1);

    logic [1:0]    mode_q;
    logic [23:0]   solid_q;
    logic [1:0]    mode_eff;
    logic [23:0]   solid_eff;
    logic [CW-1:0] bar_pos;
    logic [3:0]    bar_idx;
    logic [23:0]   bar_rgb;
    logic [23:0]   pat_rgb;

    // At pixel (0,0) the live inputs are used so the whole frame, including
    // its first pixel, sees the newly sampled settings.
    assign mode_eff  = frame_pos ? mode      : mode_q;
    assign solid_eff = frame_pos ? solid_rgb : solid_q;

    // Frame-boundary sampling of pattern controls.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 2'd0;
            solid_q <= 24'h000000;
        end else if (ce && frame_pos) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
        end
    end

    // Per-line bar tracker: position within bar and bar index, aligned to h,
    // saturating at index 8 (black tail past 8*BW).
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pos <= '0;
            bar_idx <= 4'd0;
        end else if (ce) begin
            if (h_wrap) begin
                bar_pos <= '0;
                bar_idx <= 4'd0;
            end else if (bar_pos == BW_LAST) begin
                bar_pos <= '0;
                if (bar_idx != 4'd8) begin
                    bar_idx <= bar_idx + 4'd1;
                end
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end
    end

    // Colour-bar lookup: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            4'd0:    bar_rgb = 24'hFFFFFF;
            4'd1:    bar_rgb = 24'hFFFF00;
            4'd2:    bar_rgb = 24'h00FFFF;
            4'd3:    bar_rgb = 24'h00FF00;
            4'd4:    bar_rgb = 24'hFF00FF;
            4'd5:    bar_rgb = 24'hFF0000;
            4'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    // Pattern select for the pixel at the current counter position.
    always_comb begin
        pat_rgb = 24'h000000;
        case (mode_eff)
            2'd0:    pat_rgb = solid_eff;
            2'd1:    pat_rgb = bar_rgb;
            2'd2:    pat_rgb = {h[7:0], h[7:0], h[7:0]};
            default: pat_rgb = (h[3] ^ v[3]) ? 24'h000000 : 24'hFFFFFF;
        endcase
    end

    // Registered pixel data, blanked outside the active area.
    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdmi_r <= 8'h00;
            hdmi_g <= 8'h00;
            hdmi_b <= 8'h00;
        end else if (ce) begin
            hdmi_r <= active ? pat_rgb[23:16] : 8'h00;
            hdmi_g <= active ? pat_rgb[15:8]  : 8'h00;
            hdmi_b <= active ? pat_rgb[7:0]   : 8'h00;
        end
    end
`else
    // Pattern source not built: pixel data is constant black.
    logic unused_pattern_inputs;

    assign unused_pattern_inputs = ^{mode, solid_rgb};
    assign hdmi_r = 8'h00;
    assign hdmi_g = 8'h00;
    assign hdmi_b = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen using the small
// raster (16+2+2+2 pixels x 4+1+1+1 lines). Expected outputs come from a
// position-based raster model; VTG_PATTERN_EN selects whether rgb is expected.
module tb_video_timing_gen;

    localparam int HR    = 16;
    localparam int HFP   = 2;
    localparam int HSW   = 2;
    localparam int HBP   = 2;
    localparam int VR    = 4;
    localparam int VFP   = 1;
    localparam int VSW   = 1;
    localparam int VBP   = 1;
    localparam int CW    = 12;
    localparam int HT    = HR + HFP + HSW + HBP;
    localparam int VT    = VR + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW    = HR / 8;
    localparam int EW    = 4 + 24 + 2 * CW;

    localparam logic [EW-1:0] RST_VEC = '0;
    localparam logic [EW-1:0] POL_INV = {1'b0, 2'b11, {(EW-3){1'b0}}};

    // ---------------- clock / reset ----------------
    logic          hdmi_clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [1:0]    mode;
    logic [23:0]   solid_rgb;

    logic          de, hs, vs, fs;
    logic [7:0]    r, g, b;
    logic [CW-1:0] px, py;
    logic          de_n, hs_n, vs_n, fs_n;
    logic [7:0]    r_n, g_n, b_n;
    logic [CW-1:0] px_n, py_n;

    always #5 hdmi_clk = ~hdmi_clk;

    video_timing_gen #(
        .HR(HR), .HFP(HFP), .HS(HSW), .HBP(HBP),
        .VR(VR), .VFP(VFP), .VS(VSW), .VBP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut (
        .hdmi_clk(hdmi_clk), .rst_n(rst_n), .ce(ce), .mode(mode),
        .solid_rgb(solid_rgb), .hdmi_de(de), .hdmi_hs(hs), .hdmi_vs(vs),
        .hdmi_r(r), .hdmi_g(g), .hdmi_b(b), .pix_x(px), .pix_y(py),
        .frame_start(fs)
    );

    video_timing_gen #(
        .HR(HR), .HFP(HFP), .HS(HSW), .HBP(HBP),
        .VR(VR), .VFP(VFP), .VS(VSW), .VBP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut_n (
        .hdmi_clk(hdmi_clk), .rst_n(rst_n), .ce(ce), .mode(mode),
        .solid_rgb(solid_rgb), .hdmi_de(de_n), .hdmi_hs(hs_n), .hdmi_vs(vs_n),
        .hdmi_r(r_n), .hdmi_g(g_n), .hdmi_b(b_n), .pix_x(px_n), .pix_y(py_n),
        .frame_start(fs_n)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur_exp = RST_VEC;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] act_vec();
        return {de, hs, vs, fs, r, g, b, px, py};
    endfunction

    function automatic logic [EW-1:0] act_vec_n();
        return {de_n, hs_n, vs_n, fs_n, r_n, g_n, b_n, px_n, py_n};
    endfunction

    // ---------------- reference model ----------------
    // m_p is the linear raster position the DUT counters hold before the
    // next active edge; reset places it at the start of line VR.
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          m_p = VR * HT;
    int          m_h, m_v;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_solid = 24'h0;
    logic [CW-1:0] m_px = '0, m_py = '0;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_rgb;

    always @(posedge hdmi_clk) begin
        if (!rst_n) begin
            m_p = VR * HT;
            m_px = '0;
            m_py = '0;
            exp_q.delete();
        end else if (ce) begin
            m_h  = m_p % HT;
            m_v  = m_p / HT;
            e_de = (m_h < HR) && (m_v < VR);
            e_hs = (m_h >= HR + HFP) && (m_h < HR + HFP + HSW);
            e_vs = (m_v >= VR + VFP) && (m_v < VR + VFP + VSW);
            e_fs = (m_p == 0);
            if (m_p == 0) begin
                m_mode  = mode;
                m_solid = solid_rgb;
            end
            e_rgb = 24'h0;
`ifdef VTG_PATTERN_EN
            if (e_de) begin
                case (m_mode)
                    2'd0: e_rgb = m_solid;
                    2'd1: e_rgb = (m_h / BW < 8) ? bar_tab[m_h / BW] : 24'h0;
                    2'd2: e_rgb = {3{8'(m_h)}};
                    default: e_rgb = ((((m_h / 8) % 2) ^ ((m_v / 8) % 2)) == 0) ? 24'hFFFFFF : 24'h0;
                endcase
            end
`endif
            if (e_de) begin
                m_px = CW'(m_h);
                m_py = CW'(m_v);
            end
            exp_q.push_back({e_de, e_hs, e_vs, e_fs, e_rgb, m_px, m_py});
            m_p = (m_p + 1) % FRAME;
        end
    end

    // ---------------- monitor ----------------
    // A new expected value is consumed on every edge the DUT advanced; on
    // ce=0 edges the previous value must still be presented.
    always begin
        @(posedge hdmi_clk);
        #1;
        if (!rst_n) begin
            cur_exp = RST_VEC;
        end else if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
        end
        check("outputs", act_vec(), cur_exp);
        check("outputs_pol0", act_vec_n(), cur_exp ^ POL_INV);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_first_frame_start();
        int k;
        logic found;
        k = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge hdmi_clk);
            #1;
            k++;
            if (fs) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || k != 67) begin
            errors++;
            $display("FAIL first_frame_start found=%0d clocks=%0d expected=67", found, k);
        end
    endtask

    task automatic do_reset();
        @(negedge hdmi_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge hdmi_clk);
        rst_n = 1'b1;
        ce = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic hit;
        rst_n = 1'b0;
        ce = 1'b0;
        mode = 2'd1;
        solid_rgb = 24'h0;
        do_reset();
        wait_first_frame_start();

        // Full-rate frames: bars, then a mid-frame switch at line 2 each frame.
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge hdmi_clk);
            if (m_p == 2 * HT) begin
                mode = (mode == 2'd2) ? 2'd0 : 2'd2;
                solid_rgb = 24'($urandom);
            end
        end

        // Random ce and random control changes.
        for (int i = 0; i < 2000; i++) begin
            @(negedge hdmi_clk);
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) solid_rgb = 24'($urandom);
        end

        // Alternating ce: every output value held for two clocks.
        mode = 2'd3;
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            @(negedge hdmi_clk);
            ce = (i % 2 == 0);
        end

        // Async reset at counter position h=7, v=1.
        @(negedge hdmi_clk);
        ce = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge hdmi_clk);
            #2;
            if (m_p == HT + 7) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_h7_v1 actual=0 expected=1");
        end
        rst_n = 1'b0;
        #1;
        check("async_reset", act_vec(), RST_VEC);
        check("async_reset_pol0", act_vec_n(), RST_VEC ^ POL_INV);
        repeat (3) @(negedge hdmi_clk);
        rst_n = 1'b1;
        ce = 1'b1;
        mode = 2'd1;
        wait_first_frame_start();
        repeat (FRAME + 5) @(negedge hdmi_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
